mu0_sequencer: RTL

- Phase sequencer and instruction register for the MU0 core; the producer side of the instruction decoder's control interface.
- Generates the one-hot phase strobes fetch/exec1/exec2 and presents the current opcode (mux2r) and the opcode held into exec2 (premux2r).
- Consumes the decoder's extra flag to choose 1- or 2-cycle execution; handles STP halt, start and single-step control, and performance counters.

---
 rtl/mu0_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mu0_sequencer.sv
// MU0 phase sequencer and instruction register: drives fetch/exec1/exec2 strobes,
// holds the current and previous opcode, and counts retired instructions and busy cycles.
module mu0_sequencer #(
  parameter int OPW   = 4,
  parameter int ADDRW = 12,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic [OPW+ADDRW-1:0] ram_data,
  input  logic                 extra,
  output logic                 fetch,
  output logic                 exec1,
  output logic                 exec2,
  output logic [OPW-1:0]       mux2r,
  output logic [OPW-1:0]       premux2r,
  output logic [ADDRW-1:0]     operand,
  output logic                 running,
  output logic                 halted,
  output logic [CNTW-1:0]      instr_count,
  output logic [CNTW-1:0]      cycle_count
);

  localparam logic [OPW-1:0] OP_STA = OPW'(1);
  localparam logic [OPW-1:0] OP_STP = OPW'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_PAUSE,
    S_HALT
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_retire;
  logic                   w_running;
  logic [OPW+ADDRW-1:0]   r_ir;
  logic [OPW-1:0]         r_premux;
  logic [CNTW-1:0]        r_instr_cnt;
  logic [CNTW-1:0]        r_cycle_cnt;

  // During FETCH the word is still on the RAM bus, so decode it before IR captures it.
  assign mux2r   = (r_state == S_FETCH) ? ram_data[OPW+ADDRW-1:ADDRW] : r_ir[OPW+ADDRW-1:ADDRW];
  assign operand = (r_state == S_FETCH) ? ram_data[ADDRW-1:0]         : r_ir[ADDRW-1:0];

  assign w_running = (r_state == S_FETCH) || (r_state == S_EXEC1) || (r_state == S_EXEC2);

  assign fetch       = (r_state == S_FETCH);
  assign exec1       = (r_state == S_EXEC1);
  assign exec2       = (r_state == S_EXEC2);
  assign running     = w_running;
  assign halted      = (r_state == S_HALT);
  assign premux2r    = r_premux;
  assign instr_count = r_instr_cnt;
  assign cycle_count = r_cycle_cnt;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (mux2r == OP_STP) begin
          w_next = S_HALT;
        end else if (mux2r == OP_STA) begin
          w_retire = 1'b1;
          w_next   = step_mode ? S_PAUSE : S_FETCH;
        end else begin
          w_next = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (extra) begin
          w_next = S_EXEC2;
        end else begin
          w_retire = 1'b1;
          w_next   = step_mode ? S_PAUSE : S_FETCH;
        end
      end
      S_EXEC2: begin
        w_retire = 1'b1;
        w_next   = step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE: begin
        // A step pulse and dropping step_mode together still yield a single fetch.
        if (step || !step_mode) w_next = S_FETCH;
      end
      S_HALT: begin
        if (start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir     <= '0;
      r_premux <= '0;
    end else begin
      if (r_state == S_FETCH) r_ir     <= ram_data;
      if (r_state == S_EXEC1) r_premux <= r_ir[OPW+ADDRW-1:ADDRW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (w_retire)  r_instr_cnt <= r_instr_cnt + CNTW'(1);
      if (w_running) r_cycle_cnt <= r_cycle_cnt + CNTW'(1);
    end
  end

endmodule
